mc_controller: RTL and testbench

//  Multi-cycle main control FSM for the MIPS datapath: decodes the latched IR
//  and sequences FETCH/DECODE/EXEC/MEM/WB, driving datapath enables and the
//  4-bit ALUOp consumed by the ALU. Owns only the control path.

---
 rtl/mc_controller_pkg.sv | 74 +++++++
 rtl/mc_controller_instr_class_dec.sv | 40 ++++
 rtl/mc_controller.sv | 139 +++++++++++++
 tb/tb_mc_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, ALUOp codes,
// FSM states, datapath selector values and the one-hot instruction class vector.
package mc_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_RAS   = 6'b111111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_RAS  = 4'b1000;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [1:0] PCSRC_PC4 = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JAL = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic sll;
    logic ras;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
  } iclass_t;

  function automatic logic [3:0] alu_op_of(input iclass_t c);
    logic [3:0] op;
    op = ALU_ADD;
    if (c.subu || c.beq) op = ALU_SUB;
    else if (c.ori)      op = ALU_OR;
    else if (c.slt)      op = ALU_SLT;
    else if (c.lui)      op = ALU_LUI;
    else if (c.sll)      op = ALU_SLL;
    else if (c.ras)      op = ALU_RAS;
    return op;
  endfunction

endpackage

// File: rtl/mc_controller_instr_class_dec.sv
// Combinational opcode/funct classifier producing a one-hot class vector plus illegal.
// Optional CTRL_RAS_EN: when defined, R-type funct 6'b111111 decodes as ras instead of illegal.
module instr_class_dec
  import mc_controller_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic       illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_SLT:  cls.slt  = 1'b1;
          FN_SLL:  cls.sll  = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
`ifdef CTRL_RAS_EN
          FN_RAS:  cls.ras  = 1'b1;
`endif
          default: ;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: ;
    endcase
  end

  assign illegal = (cls == '0);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main control FSM (FETCH/DECODE/EXEC/MEM/WB) with Moore output decode.
// Optional CTRL_RAS_EN (handled in instr_class_dec) adds the ras R-type instruction.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MEM_WAIT_EN_CYC = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic [3:0] ALUOp,
  output logic       illegal
);

  localparam logic [1:0] MEM_LAST = 2'(MEM_WAIT_EN_CYC);

  logic [2:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  iclass_t    cls;
  logic       dec_illegal;
  logic       r_alu;
  logic       mem_last;

  instr_class_dec u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  assign r_alu    = cls.addu | cls.subu | cls.slt | cls.sll | cls.ras;
  assign mem_last = (cnt_q == MEM_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The wait counter is cleared on the way into MEM so every memory access starts fresh.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_illegal || cls.jr) state_d = ST_FETCH;
        else if (cls.jal)          state_d = ST_WB;
        else                       state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_d = 2'd0;
        if (cls.beq)                 state_d = ST_FETCH;
        else if (cls.lw || cls.sw)   state_d = ST_MEM;
        else                         state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_last) begin
          cnt_d   = 2'd0;
          state_d = cls.sw ? ST_FETCH : ST_WB;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Reset masks every output combinationally so an aborted instruction never writes.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = PCSRC_PC4;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = REGDST_RT;
    WDSel    = WD_ALU;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    ALUOp    = ALU_ADD;
    illegal  = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        ST_DECODE: begin
          illegal = dec_illegal;
          if (cls.jr) begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JR;
          end
        end
        ST_EXEC: begin
          ALUOp  = alu_op_of(cls);
          ALUSrc = cls.ori | cls.lui | cls.lw | cls.sw;
          ExtOp  = cls.lw | cls.sw | cls.beq;
          if (cls.beq) begin
            PCWrite = zero;
            PCSrc   = PCSRC_BR;
          end
        end
        ST_MEM:   MemWrite = cls.sw & mem_last;
        ST_WB: begin
          RegWrite = 1'b1;
          if (r_alu) begin
            RegDst = REGDST_RD;
          end else if (cls.lw) begin
            WDSel = WD_MEM;
          end else if (cls.jal) begin
            RegDst  = REGDST_RA;
            WDSel   = WD_PC4;
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JAL;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: an instruction-timeline reference model queues the
// expected control word for every cycle and a monitor compares on the falling edge.
module tb_mc_controller;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, ALUSrc, ExtOp, illegal;
  logic [1:0] PCSrc, RegDst, WDSel;
  logic [3:0] ALUOp;

  mc_controller #(.MEM_WAIT_EN_CYC(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .WDSel    (WDSel),
    .MemWrite (MemWrite),
    .ALUSrc   (ALUSrc),
    .ExtOp    (ExtOp),
    .ALUOp    (ALUOp),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       rw;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       mw;
    logic       alusrc;
    logic       extop;
    logic [3:0] aluop;
    logic       ill;
  } ctl_t;

  typedef enum int {K_ADDU, K_SUBU, K_SLT, K_SLL, K_RAS, K_ORI, K_LUI,
                    K_LW, K_SW, K_BEQ, K_JAL, K_JR, K_ILL} kind_t;

  typedef struct {
    ctl_t v;
    int   id;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   instr_id = 0;
  ctl_t got;

  assign got = {PCWrite, PCSrc, IRWrite, RegWrite, RegDst, WDSel,
                MemWrite, ALUSrc, ExtOp, ALUOp, illegal};

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h21: return K_ADDU;
          6'h23: return K_SUBU;
          6'h2a: return K_SLT;
          6'h00: return K_SLL;
          6'h08: return K_JR;
          6'h3f: begin
`ifdef CTRL_RAS_EN
            return K_RAS;
`else
            return K_ILL;
`endif
          end
          default: return K_ILL;
        endcase
      end
      6'h0d:   return K_ORI;
      6'h0f:   return K_LUI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h03:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int cpi(input kind_t k);
    case (k)
      K_BEQ, K_JAL: return 3;
      K_JR, K_ILL:  return 2;
      K_LW:         return 5 + W;
      K_SW:         return 4 + W;
      default:      return 4;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input kind_t k);
    case (k)
      K_SUBU, K_BEQ: return 4'b0001;
      K_ORI:         return 4'b0010;
      K_SLT:         return 4'b0011;
      K_LUI:         return 4'b0100;
      K_SLL:         return 4'b0101;
      K_RAS:         return 4'b1000;
      default:       return 4'b0000;
    endcase
  endfunction

  // Expected control word for cycle c (0 = fetch) of an instruction of kind k.
  function automatic ctl_t exp_at(input kind_t k, input int c, input logic z);
    ctl_t e;
    int   wb_cyc;
    e = '0;
    wb_cyc = (k == K_JAL) ? 2 : (k == K_LW) ? 4 + W : 3;
    if (c == 0) begin
      e.irw = 1'b1;
      e.pcw = 1'b1;
    end else if (c == 1) begin
      if (k == K_ILL) e.ill = 1'b1;
      if (k == K_JR) begin
        e.pcw   = 1'b1;
        e.pcsrc = 2'd3;
      end
    end else if (c == 2 && k != K_JAL) begin
      e.aluop  = alu_code(k);
      e.alusrc = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
      e.extop  = (k == K_LW || k == K_SW || k == K_BEQ);
      if (k == K_BEQ) begin
        e.pcw   = z;
        e.pcsrc = 2'd1;
      end
    end else if (k == K_SW) begin
      e.mw = (c == 3 + W);
    end else if (c == wb_cyc && k != K_LW) begin
      e.rw = 1'b1;
      if (k == K_JAL) begin
        e.regdst = 2'd2;
        e.wdsel  = 2'd2;
        e.pcw    = 1'b1;
        e.pcsrc  = 2'd2;
      end else if (k != K_ORI && k != K_LUI) begin
        e.regdst = 2'd1;
      end
    end else if (c == wb_cyc && k == K_LW) begin
      e.rw    = 1'b1;
      e.wdsel = 2'd1;
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input ctl_t e, input int cyc);
    exp_t x;
    @(posedge clk);
    #1;
    reset  = r;
    opcode = op;
    funct  = fn;
    zero   = z;
    x.v   = e;
    x.id  = instr_id;
    x.cyc = cyc;
    sb.push_back(x);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    kind_t k;
    k = classify(op, fn);
    for (int c = 0; c < cpi(k); c++) drive(1'b0, op, fn, z, exp_at(k, c, z), c);
    instr_id++;
  endtask

  // sw aborted by reset in its last MEM cycle: that cycle must be completely quiet.
  task automatic run_sw_reset();
    for (int c = 0; c < 3 + W; c++) drive(1'b0, 6'h2b, 6'h00, 1'b0, exp_at(K_SW, c, 1'b0), c);
    drive(1'b1, 6'h2b, 6'h00, 1'b0, '0, 3 + W);
    instr_id++;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_chk++;
        if (got !== x.v) begin
          n_fail++;
          $display("FAIL ctl instr%0d cyc%0d got=%h exp=%h", x.id, x.cyc, got, x.v);
        end
      end
    end
  end

  initial begin : stim
    logic [5:0] tbl_op [13];
    logic [5:0] tbl_fn [13];
    int         sel;
    tbl_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f,
               6'h23, 6'h2b, 6'h04, 6'h03, 6'h3f};
    tbl_fn = '{6'h21, 6'h23, 6'h2a, 6'h00, 6'h08, 6'h3f, 6'h15, 6'h2a,
               6'h00, 6'h3f, 6'h21, 6'h08, 6'h00};

    drive(1'b1, 6'h00, 6'h21, 1'b0, '0, 0);
    drive(1'b1, 6'h00, 6'h21, 1'b0, '0, 1);
    instr_id++;

    run_instr(6'h00, 6'h21, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b1);
    run_instr(6'h03, 6'h00, 1'b0);
    run_instr(6'h00, 6'h08, 1'b0);
    run_instr(6'h3f, 6'h00, 1'b0);
    run_instr(6'h00, 6'h3f, 1'b0);
    run_sw_reset();
    run_instr(6'h00, 6'h00, 1'b0);
    run_instr(6'h00, 6'h23, 1'b1);
    run_instr(6'h00, 6'h2a, 1'b0);
    run_instr(6'h0d, 6'h00, 1'b0);
    run_instr(6'h0f, 6'h00, 1'b0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_instr(6'($urandom), 6'($urandom), 1'($urandom));
      end else begin
        sel = $urandom_range(0, 12);
        run_instr(tbl_op[sel], tbl_fn[sel], 1'($urandom));
      end
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
